// File: rtl/vga_sync_ctrl_pkg.sv
// Shared types and default timing for the VGA raster sequencer.
package vga_sync_ctrl_pkg;

    // Per-axis scan phase; the encoding is fixed so downstream decode stays stable.
    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } phase_e;

    // Default 640x480@60 timing.
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Phase to enter after an advancing tick at count cnt. The phase is left when
    // the count sits on the phase's last value.
    function automatic phase_e phase_next(phase_e ph, int cnt,
                                          int n_act, int n_fp, int n_sync, int n_bp);
        phase_e nxt;
        nxt = ph;
        case (ph)
            PH_ACT:  if (cnt == n_act - 1)                       nxt = PH_FP;
            PH_FP:   if (cnt == n_act + n_fp - 1)                nxt = PH_SYNC;
            PH_SYNC: if (cnt == n_act + n_fp + n_sync - 1)       nxt = PH_BP;
            PH_BP:   if (cnt == n_act + n_fp + n_sync + n_bp - 1) nxt = PH_ACT;
            default:                                             nxt = PH_ACT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/vga_sync_ctrl_if.sv
// Control inputs and raster outputs of the VGA sync controller.
interface vga_sync_ctrl_if #(
    parameter int H_WIDTH = 10,
    parameter int V_WIDTH = 10
);
    logic               i_sclr;
    logic               i_en;
    logic [H_WIDTH-1:0] o_hcnt;
    logic [V_WIDTH-1:0] o_vcnt;
    logic               o_hsync;
    logic               o_vsync;
    logic               o_de;
    logic               o_frame_start;

    // Driver side (pixel-tick source / pipeline).
    modport master (
        output i_sclr, i_en,
        input  o_hcnt, o_vcnt, o_hsync, o_vsync, o_de, o_frame_start
    );

    // Sync controller side.
    modport slave (
        input  i_sclr, i_en,
        output o_hcnt, o_vcnt, o_hsync, o_vsync, o_de, o_frame_start
    );
endinterface

// File: rtl/vga_sync_ctrl_cnt.sv
// Mod-ULIMIT counter with sync clear, enable and async active-low reset.
// o_wrap flags the enabled tick that rolls the count back to 0.
module counterN_en_arst #(
    parameter int ULIMIT = 800,
    parameter int WIDTH  = 10
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_sclr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_wrap
);
    logic [WIDTH-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == WIDTH'(ULIMIT - 1));
    assign o_wrap = i_en & w_last;
    assign o_cnt  = r_cnt;

    // Count register: clear wins over enable, wrap at ULIMIT-1.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n)    r_cnt <= '0;
        else if (i_sclr) r_cnt <= '0;
        else if (i_en)   r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA raster sequencer: chained column/line counters, per-axis phase FSMs and
// registered sync/enable/frame-start outputs aligned with the counts.
module vga_sync_ctrl
    import vga_sync_ctrl_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int H_WIDTH  = 10,
    parameter int V_WIDTH  = 10,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic           clk,
    input  logic           i_rst_n,
    vga_sync_ctrl_if.slave bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [H_WIDTH-1:0] w_hcnt;
    logic [V_WIDTH-1:0] w_vcnt;
    logic               w_hwrap;
    logic               w_vwrap;
    phase_e             r_hph, r_vph, w_hph_nxt, w_vph_nxt;
    logic               r_hsync, r_vsync, r_de, r_fs;

    counterN_en_arst #(.ULIMIT(H_TOTAL), .WIDTH(H_WIDTH)) u_hcnt (
        .clk    (clk),
        .i_rst_n(i_rst_n),
        .i_sclr (bus.i_sclr),
        .i_en   (bus.i_en),
        .o_cnt  (w_hcnt),
        .o_wrap (w_hwrap)
    );

    // Line counter only steps on the column wrap.
    counterN_en_arst #(.ULIMIT(V_TOTAL), .WIDTH(V_WIDTH)) u_vcnt (
        .clk    (clk),
        .i_rst_n(i_rst_n),
        .i_sclr (bus.i_sclr),
        .i_en   (w_hwrap),
        .o_cnt  (w_vcnt),
        .o_wrap (w_vwrap)
    );

    // Phase state registers for both axes.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hph <= PH_ACT;
            r_vph <= PH_ACT;
        end else begin
            r_hph <= w_hph_nxt;
            r_vph <= w_vph_nxt;
        end
    end

    // Next phase: H advances on a pixel tick, V only on an H wrap tick.
    always_comb begin
        w_hph_nxt = r_hph;
        w_vph_nxt = r_vph;
        if (bus.i_sclr) begin
            w_hph_nxt = PH_ACT;
            w_vph_nxt = PH_ACT;
        end else begin
            if (bus.i_en)
                w_hph_nxt = phase_next(r_hph, int'(w_hcnt), H_ACTIVE, H_FP, H_SYNC, H_BP);
            if (w_hwrap)
                w_vph_nxt = phase_next(r_vph, int'(w_vcnt), V_ACTIVE, V_FP, V_SYNC, V_BP);
        end
    end

    // Outputs load the decode of the next phases so they line up with the counts.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
            r_de    <= 1'b1;
            r_fs    <= 1'b0;
        end else begin
            r_hsync <= (w_hph_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_vsync <= (w_vph_nxt == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            r_de    <= (w_hph_nxt == PH_ACT) && (w_vph_nxt == PH_ACT);
            r_fs    <= ~bus.i_sclr & w_vwrap;
        end
    end

    assign bus.o_hcnt        = w_hcnt;
    assign bus.o_vcnt        = w_vcnt;
    assign bus.o_hsync       = r_hsync;
    assign bus.o_vsync       = r_vsync;
    assign bus.o_de          = r_de;
    assign bus.o_frame_start = r_fs;
endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Directed plus randomized bench for vga_sync_ctrl on a reduced 8x6 raster.
module tb_vga_sync_ctrl;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam bit SP = 1'b0;

    logic clk = 1'b0;
    logic rst_n;
    int   n_asrt = 0;
    int   n_fail = 0;

    // Reference position and frame-start flag.
    int   m_h, m_v;
    bit   m_fs;
    int   fs_cnt;

    always #5 clk = ~clk;

    vga_sync_ctrl_if #(.H_WIDTH(4), .V_WIDTH(4)) bus ();

    vga_sync_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .H_WIDTH(4), .V_WIDTH(4), .SYNC_POL(SP)
    ) dut (
        .clk    (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d (model h=%0d v=%0d)", tag, got, exp, m_h, m_v);
        end
    endtask

    // Expected outputs come straight from the raster position.
    task automatic chk_all(input string tag);
        chk({tag, "_hcnt"},  int'(bus.o_hcnt), m_h);
        chk({tag, "_vcnt"},  int'(bus.o_vcnt), m_v);
        chk({tag, "_de"},    int'(bus.o_de), (m_h < HA && m_v < VA) ? 1 : 0);
        chk({tag, "_hsync"}, int'(bus.o_hsync),
            (m_h >= HA + HF && m_h < HA + HF + HS) ? int'(SP) : int'(!SP));
        chk({tag, "_vsync"}, int'(bus.o_vsync),
            (m_v >= VA + VF && m_v < VA + VF + VS) ? int'(SP) : int'(!SP));
        chk({tag, "_fs"},    int'(bus.o_frame_start), int'(m_fs));
    endtask

    task automatic model_reset();
        m_h = 0; m_v = 0; m_fs = 1'b0;
    endtask

    // One clock with the given inputs; model advances by linear pixel index.
    task automatic step(input bit en, input bit sclr, input string tag);
        int p;
        bus.i_en   = en;
        bus.i_sclr = sclr;
        @(posedge clk);
        if (sclr) begin
            model_reset();
        end else if (en) begin
            p    = (m_v * HT + m_h + 1) % (HT * VT);
            m_h  = p % HT;
            m_v  = p / HT;
            m_fs = (p == 0);
        end else begin
            m_fs = 1'b0;
        end
        #1;
        if (bus.o_frame_start) fs_cnt++;
        chk_all(tag);
    endtask

    initial begin
        bus.i_en   = 1'b0;
        bus.i_sclr = 1'b0;
        rst_n      = 1'b0;
        fs_cnt     = 0;
        model_reset();
        #12;
        chk_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running line: 0..7 and back to 0 on the next line.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, "line");

        // Restart, run to the end of line 0, cross into line 1.
        step(1'b0, 1'b1, "sclr0");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, "toend");
        chk("at7_h", int'(bus.o_hcnt), 7);
        step(1'b1, 1'b0, "nextline");
        chk("line1_v", int'(bus.o_vcnt), 1);

        // Finish the frame and a full one more; exactly one frame-start per wrap.
        fs_cnt = 0;
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, "frameA");
        chk("fsA_cnt", fs_cnt, 1);
        fs_cnt = 0;
        for (int i = 0; i < 48; i++) step(1'b1, 1'b0, "frameB");
        chk("fsB_cnt", fs_cnt, 1);

        // Alternating enable across a frame boundary.
        fs_cnt = 0;
        for (int i = 0; i < 100; i++) step(i[0] == 1'b0, 1'b0, "toggle");
        chk("fsT_cnt", fs_cnt, 1);

        // Sync clear at (5,4) with enable high.
        for (int i = 0; i < 100 && !(m_h == 5 && m_v == 4); i++) step(1'b1, 1'b0, "to54");
        chk("reach54_h", int'(bus.o_hcnt), 5);
        chk("reach54_v", int'(bus.o_vcnt), 4);
        step(1'b1, 1'b1, "sclr54");
        chk("sclr54_hs", int'(bus.o_hsync), 1);

        // Async reset pulse mid-cycle at (6,2).
        for (int i = 0; i < 100 && !(m_h == 6 && m_v == 2); i++) step(1'b1, 1'b0, "to62");
        chk("reach62_h", int'(bus.o_hcnt), 6);
        chk("reach62_v", int'(bus.o_vcnt), 2);
        bus.i_en = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        model_reset();
        chk_all("arst");
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "resume");

        // Randomized enables with occasional clears.
        for (int i = 0; i < 400; i++)
            step(($urandom % 4) != 0, ($urandom % 50) == 0, "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
